// File: rtl/rr_resource_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// rr_resource_arbiter_pkg
//   Shared types and helpers for the round-robin resource arbiter.
//   - arb_state_e : arbiter FSM state (IDLE / OWNED)
//   - pick_t      : result of a round-robin search {found, idx}
//   - rr_pick()   : first set bit of req_vec searching upward from ptr, mod n
//   - onehot()    : index -> one-hot vector
//   The helpers work on a fixed MAX_REQ-wide vector so they can live in the
//   package; callers zero-extend their request vector and slice the result.
// ----------------------------------------------------------------------------
package rr_resource_arbiter_pkg;

    localparam int MAX_REQ = 32;
    localparam int IDX_W   = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // Round-robin search: position ptr has the highest priority, ptr-1 the lowest.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req_vec,
                                      input logic [IDX_W-1:0]   ptr,
                                      input int                 n);
        pick_t p;
        int    j;
        p = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= n) begin
                j = j - n;
            end
            if ((k < n) && !p.found) begin
                if (req_vec[j[IDX_W-1:0]]) begin
                    p.found = 1'b1;
                    p.idx   = j[IDX_W-1:0];
                end
            end
        end
        return p;
    endfunction

    function automatic logic [MAX_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [MAX_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_resource_arbiter_tag_pipe.sv
// ----------------------------------------------------------------------------
// rr_resource_arbiter_tag_pipe
//   RES_LAT-deep shift register of {valid, requester index} that travels in
//   lock-step with the shared resource, so each result can be routed back to
//   the requester that issued it. Never stalls.
// Ports:
//   clk, reset      clock (rising edge), asynchronous active-high reset
//   i_valid, i_idx  tag entering the pipe this cycle
//   o_valid, o_idx  tag emerging RES_LAT cycles later
// ----------------------------------------------------------------------------
module rr_resource_arbiter_tag_pipe #(
    parameter int RES_LAT = 2,
    parameter int TAG_W   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    input  logic [TAG_W-1:0] i_idx,
    output logic             o_valid,
    output logic [TAG_W-1:0] o_idx
);

    logic [RES_LAT-1:0] r_valid;
    logic [TAG_W-1:0]   r_idx [RES_LAT];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            for (int k = 0; k < RES_LAT; k++) begin
                r_idx[k] <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_idx[0]   <= i_idx;
            for (int k = 1; k < RES_LAT; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_idx[k]   <= r_idx[k-1];
            end
        end
    end

    assign o_valid = r_valid[RES_LAT-1];
    assign o_idx   = r_idx[RES_LAT-1];

endmodule

// File: rtl/rr_resource_arbiter.sv
// ----------------------------------------------------------------------------
// rr_resource_arbiter
//   Owns a shared resource contended for by NUM_REQ pipelines. Round-robin
//   arbitration with a hold limit under contention, operand mux into the
//   resource, and per-requester routing of results via a tag pipe.
// Ports:
//   clk, reset     clock (rising edge), asynchronous active-high reset
//   req            request per pipeline
//   req_data       operand per pipeline, slice i = [i*DATA_W +: DATA_W]
//   grant          registered grant, one-hot or zero
//   res_in         operand of current owner (0 when nobody holds grant)
//   res_in_valid   res_in is a real transaction this cycle
//   res_out        resource result, RES_LAT cycles after res_in_valid
//   res_out_data   res_out broadcast to every pipeline
//   res_out_valid  one-hot: res_out_data belongs to requester i
//   busy           FSM is in OWNED
// Handshake: a transaction is issued in every cycle where the owner's grant
//   and req are both high; its result returns exactly RES_LAT cycles later
//   with res_out_valid marking the owner, with no back-pressure anywhere.
// ----------------------------------------------------------------------------
module rr_resource_arbiter
    import rr_resource_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 32,
    parameter int RES_LAT  = 2,
    parameter int MAX_HOLD = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic [DATA_W-1:0]         res_in,
    output logic                      res_in_valid,
    input  logic [DATA_W-1:0]         res_out,
    output logic [DATA_W-1:0]         res_out_data,
    output logic [NUM_REQ-1:0]        res_out_valid,
    output logic                      busy
);

    localparam int PTR_W  = $clog2(NUM_REQ);
    localparam int HOLD_W = $clog2(MAX_HOLD) + 1;

    arb_state_e          r_state, w_state_nxt;
    logic [PTR_W-1:0]    r_owner, w_owner_nxt;
    logic [PTR_W-1:0]    r_ptr,   w_ptr_nxt;
    logic [HOLD_W-1:0]   r_hold_cnt, w_hold_nxt;
    logic [NUM_REQ-1:0]  r_grant, w_grant_nxt;

    logic [DATA_W-1:0]   w_req_data [NUM_REQ];
    logic [MAX_REQ-1:0]  w_owner_oh_full, w_oh_idle_full, w_oh_rel_full, w_tag_oh_full;
    logic [NUM_REQ-1:0]  w_others;
    logic [PTR_W-1:0]    w_ptr_after;
    logic                w_release;
    logic                w_hold_limit;
    pick_t               w_pick_idle, w_pick_rel;
    logic                w_tag_valid;
    logic [PTR_W-1:0]    w_tag_idx;
    logic                w_unused_ok;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_req_data[g] = req_data[g*DATA_W +: DATA_W];
    end

    // Competitors of the current owner; the owner itself is excluded so a
    // forced release always hands over when someone else is waiting.
    assign w_owner_oh_full = onehot(IDX_W'(r_owner));
    assign w_others        = req & ~w_owner_oh_full[NUM_REQ-1:0];
    assign w_ptr_after     = (r_owner == PTR_W'(NUM_REQ-1)) ? '0 : r_owner + 1'b1;

    // The counter keeps running during solo ownership, so ">=" makes a late
    // competitor force the hand-over at once instead of waiting for a wrap.
    assign w_hold_limit = (r_hold_cnt >= HOLD_W'(MAX_HOLD-1));
    assign w_release    = ~req[r_owner] | (w_hold_limit & (|w_others));

    assign w_pick_idle    = rr_pick(MAX_REQ'(req), IDX_W'(r_ptr), NUM_REQ);
    assign w_pick_rel     = rr_pick(MAX_REQ'(w_others), IDX_W'(w_ptr_after), NUM_REQ);
    assign w_oh_idle_full = onehot(w_pick_idle.idx);
    assign w_oh_rel_full  = onehot(w_pick_rel.idx);

    // State register (grant is part of the registered state).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_owner    <= '0;
            r_ptr      <= '0;
            r_hold_cnt <= '0;
            r_grant    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_ptr      <= w_ptr_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_grant    <= w_grant_nxt;
        end
    end

    // Next-state logic. Grant is always built from a single index, so it can
    // never become multi-hot.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_grant_nxt = r_grant;
        w_hold_nxt  = (r_hold_cnt == '1) ? r_hold_cnt : r_hold_cnt + 1'b1;
        case (r_state)
            IDLE: begin
                w_hold_nxt  = '0;
                w_grant_nxt = '0;
                if (w_pick_idle.found) begin
                    w_state_nxt = OWNED;
                    w_owner_nxt = w_pick_idle.idx[PTR_W-1:0];
                    w_grant_nxt = w_oh_idle_full[NUM_REQ-1:0];
                end
            end
            OWNED: begin
                if (w_release) begin
                    w_ptr_nxt  = w_ptr_after;
                    w_hold_nxt = '0;
                    if (w_pick_rel.found) begin
                        // Direct hand-over: no idle bubble between owners.
                        w_owner_nxt = w_pick_rel.idx[PTR_W-1:0];
                        w_grant_nxt = w_oh_rel_full[NUM_REQ-1:0];
                    end else begin
                        w_state_nxt = IDLE;
                        w_grant_nxt = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    rr_resource_arbiter_tag_pipe #(
        .RES_LAT (RES_LAT),
        .TAG_W   (PTR_W)
    ) u_tag_pipe (
        .clk     (clk),
        .reset   (reset),
        .i_valid (res_in_valid),
        .i_idx   (r_owner),
        .o_valid (w_tag_valid),
        .o_idx   (w_tag_idx)
    );

    assign w_tag_oh_full = onehot(IDX_W'(w_tag_idx));

    // Output logic.
    always_comb begin
        grant         = r_grant;
        busy          = (r_state == OWNED);
        res_in        = (|r_grant) ? w_req_data[r_owner] : '0;
        res_in_valid  = |(r_grant & req);
        res_out_data  = res_out;
        res_out_valid = w_tag_valid ? w_tag_oh_full[NUM_REQ-1:0] : '0;
    end

    assign w_unused_ok = ^{w_owner_oh_full, w_oh_idle_full, w_oh_rel_full,
                           w_tag_oh_full, w_pick_idle.idx, w_pick_rel.idx};

endmodule
